// File: rtl/encoder_rr.sv
// encoder_rr: registered N:log2(N) round-robin priority encoder with a
// valid/ready output stage. The request vector is sampled into an output
// register, so there is no combinational path from req to the outputs.
// Optional feature macro: ENCODER_RR_ROTATE_EN. When it is defined, a
// rotating priority pointer makes the grant fair. When it is undefined,
// the pointer is removed and the lowest set request bit always wins.
module encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_index,
  output logic [N-1:0] out_onehot
);

  // Index of the lowest set bit of v; zero when v is empty (callers gate on |v).
  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  logic         load;
  logic         any_req;
  logic [W-1:0] grant_next;

  // The output register may take a new value when it is empty or being drained.
  assign load    = !out_valid || out_ready;
  assign any_req = |req;

`ifdef ENCODER_RR_ROTATE_EN
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;
  logic [N-1:0] high_mask;
  logic [N-1:0] req_high;

  // high_mask marks requesters at or above the pointer; they win over the
  // wrapped-around requesters below it.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign high_mask[gi] = (W'(gi) >= ptr_reg);
    end
  endgenerate

  assign req_high = req & high_mask;

  // Scan from the pointer upwards; if nothing is set there, wrap to bit 0.
  always_comb begin
    grant_next = lowest_set(req);
    if (|req_high) grant_next = lowest_set(req_high);
  end

  // The pointer moves just past the winner; N is a power of two, so the
  // W-bit add wraps N-1 back to 0 for free.
  assign ptr_next = grant_next + W'(1);

  // Pointer advances only when a grant is actually loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (load && any_req) begin
      ptr_reg <= ptr_next;
    end
  end
`else
  // Fixed priority: the lowest-index requester always wins.
  assign grant_next = lowest_set(req);
`endif

  // Output register: load a grant, go empty on no requests, or hold under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
    end else if (load) begin
      out_valid <= any_req;
      if (any_req) out_index <= grant_next;
    end
  end

  // One-hot copy decoded straight from the registers, forced to zero when empty.
  genvar go;
  generate
    for (go = 0; go < N; go++) begin : g_onehot
      assign out_onehot[go] = out_valid && (out_index == W'(go));
    end
  endgenerate

endmodule

// File: tb/tb_encoder_rr.sv
// Testbench for encoder_rr: three instances (N = 8, 2, 64) share one clock and
// reset. The stimulus process drives inputs just after each falling edge, steps
// a behavioural model of the encoder and queues the output state expected after
// the next rising edge. A separate monitor pops and compares on each falling edge.
module tb_encoder_rr;

  typedef struct packed {
    logic       v;
    logic [6:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req8;
  logic        rdy8;
  logic [1:0]  req2;
  logic        rdy2;
  logic [63:0] req64;
  logic        rdy64;
  logic        o8_valid, o2_valid, o64_valid;
  logic [2:0]  o8_index;
  logic        o2_index;
  logic [5:0]  o64_index;
  logic [7:0]  o8_onehot;
  logic [1:0]  o2_onehot;
  logic [63:0] o64_onehot;

  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  exp_t q8[$];
  exp_t q2[$];
  exp_t q64[$];

  // model state: one slot per instance (0: N=8, 1: N=2, 2: N=64)
  bit m_v[3];
  int m_idx[3];
  int m_ptr[3];

  always #5 clk = ~clk;

  encoder_rr #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .out_ready(rdy8),
    .out_valid(o8_valid), .out_index(o8_index), .out_onehot(o8_onehot));

  encoder_rr #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .out_ready(rdy2),
    .out_valid(o2_valid), .out_index(o2_index), .out_onehot(o2_onehot));

  encoder_rr #(.N(64)) dut64 (
    .clk(clk), .reset(reset), .req(req64), .out_ready(rdy64),
    .out_valid(o64_valid), .out_index(o64_index), .out_onehot(o64_onehot));

  // Behavioural model: search n positions starting at the pointer, modulo n.
  function automatic void model_step(input int n, input logic [63:0] r, input bit rdy,
                                     inout bit v, inout int idx, inout int p);
    if (!v || rdy) begin
      if (r == 64'd0) begin
        v = 1'b0;
      end else begin
        for (int k = 0; k < n; k++) begin
          int j;
          j = (p + k) % n;
          if (r[j]) begin
            idx = j;
            break;
          end
        end
        v = 1'b1;
`ifdef ENCODER_RR_ROTATE_EN
        p = (idx + 1) % n;
`endif
      end
    end
  endfunction

  function automatic exp_t mk(input bit v, input int idx);
    exp_t e;
    e.v   = v;
    e.idx = 7'(idx);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_v[i]   = 1'b0;
      m_idx[i] = 0;
      m_ptr[i] = 0;
    end
    q8.push_back(mk(1'b0, 0));
    q2.push_back(mk(1'b0, 0));
    q64.push_back(mk(1'b0, 0));
  endtask

  task automatic drive_small();
    req2  = 2'($urandom);
    rdy2  = ($urandom_range(0, 3) != 0);
    req64 = ($urandom_range(0, 7) == 0) ? 64'd0 :
            ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
    rdy64 = ($urandom_range(0, 3) != 0);
  endtask

  // One clock of stimulus; the queued entries describe the state after the next rising edge.
  task automatic step(input logic [7:0] r8, input bit k8);
    @(negedge clk);
    #1;
    reset = 1'b0;
    req8  = r8;
    rdy8  = k8;
    drive_small();
    model_step(8,  64'(req8),  rdy8,  m_v[0], m_idx[0], m_ptr[0]);
    model_step(2,  64'(req2),  rdy2,  m_v[1], m_idx[1], m_ptr[1]);
    model_step(64, req64,      rdy64, m_v[2], m_idx[2], m_ptr[2]);
    q8.push_back(mk(m_v[0], m_idx[0]));
    q2.push_back(mk(m_v[1], m_idx[1]));
    q64.push_back(mk(m_v[2], m_idx[2]));
  endtask

  // Reset raised between edges with all requests up; outputs must clear before any rising edge.
  task automatic reset_pulse();
    @(negedge clk);
    #1;
    req8 = 8'hFF;
    rdy8 = 1'b1;
    drive_small();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check(input string name, input bit av, input logic [63:0] ai,
                       input logic [63:0] aoh, input exp_t e);
    logic [63:0] eoh;
    eoh = e.v ? (64'd1 << e.idx) : 64'd0;
    checks++;
    if (av !== e.v || ai !== 64'(e.idx) || aoh !== eoh) begin
      errors++;
      $display("FAIL %s: got valid=%0b index=%0d onehot=%h, expected valid=%0b index=%0d onehot=%h",
               name, av, ai, aoh, e.v, e.idx, eoh);
    end
  endtask

  // Monitor: compare each instance against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check("n8", o8_valid, 64'(o8_index), 64'(o8_onehot), e);
      if (o8_valid && rdy8) $display("xfer n8 index=%0d onehot=%h", o8_index, o8_onehot);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("n2", o2_valid, 64'(o2_index), 64'(o2_onehot), e);
    end
    if (q64.size() > 0) begin
      e = q64.pop_front();
      check("n64", o64_valid, 64'(o64_index), o64_onehot, e);
    end
    if (done) begin
      checks++;
      if (q8.size() + q2.size() + q64.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d leftover expectations, expected 0",
                 q8.size() + q2.size() + q64.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b1;
    req8  = 8'h00;
    rdy8  = 1'b0;
    req2  = 2'b00;
    rdy2  = 1'b0;
    req64 = 64'd0;
    rdy64 = 1'b0;
    model_reset();

    // reset pulse with all requests up, then the first grant comes from ptr = 0
    reset_pulse();
    step(8'hFF, 1'b1);

    // rotation with a steady pattern
    for (int i = 0; i < 6; i++) step(8'b1010_0100, 1'b1);

    // backpressure: hold index 3 while req changes underneath
    step(8'h08, 1'b1);
    step(8'h80, 1'b0);
    step(8'h80, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h80, 1'b1);

    // empty, then a single requester
    step(8'h00, 1'b1);
    step(8'h10, 1'b1);

    // pointer wrap after granting 7
    step(8'h80, 1'b1);
    step(8'h81, 1'b1);
    step(8'h81, 1'b1);

    // out_ready toggling while empty
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // randomized traffic with occasional mid-run resets
    for (int c = 0; c < 10000; c++) begin
      if (c % 2500 == 1249) reset_pulse();
      step(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    done = 1'b1;
  end

endmodule
